// File: rtl/four_bank_mem_resp.sv
// Four-bank word-interleaved memory responder with per-bank busy timers and a fixed-latency read pipe.
// Optional MEM_ERR_CHK_EN adds unaligned / top-of-range address rejection to err.
module four_bank_mem_resp #(
   parameter int AW        = 16,
   parameter int DW        = 16,
   parameter int BANK_BUSY = 4,
   parameter int RD_LAT    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] data_in,
   input  logic          wr,
   input  logic          rd,
   output logic [DW-1:0] data_out,
   output logic          data_valid,
   output logic          stall,
   output logic [3:0]    busy,
   output logic          err
);

   localparam int CW    = (BANK_BUSY > 1) ? $clog2(BANK_BUSY) : 1;
   localparam int DEPTH = 2 ** (AW - 1);

   logic [CW-1:0]   r_cnt [4];
   logic [DW-1:0]   r_mem [DEPTH];
   logic [RD_LAT-1:0] r_vld;
   logic [DW-1:0]   r_dat [RD_LAT];

   logic            w_req;
   logic            w_err;
   logic            w_accept;
   logic            w_acc_rd;
   logic            w_acc_wr;
   logic [1:0]      w_bank;
   logic [AW-2:0]   w_word;

   assign w_req  = rd | wr;
   assign w_bank = addr[2:1];
   assign w_word = addr[AW-1:1];

`ifdef MEM_ERR_CHK_EN
   localparam logic [AW-1:0] LP_ADDR_LIM = {{(AW-1){1'b1}}, 1'b0};
   assign w_err = (rd & wr) | (w_req & (addr[0] | (addr >= LP_ADDR_LIM)));
`else
   logic w_unused_lsb;
   assign w_unused_lsb = addr[0];
   assign w_err = rd & wr;
`endif

   always_comb begin
      busy = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         busy[i] = (r_cnt[i] != '0);
      end
   end

   assign err      = w_err;
   assign stall    = w_req & ~w_err & busy[w_bank];
   assign w_accept = w_req & ~w_err & ~busy[w_bank];
   assign w_acc_rd = w_accept & rd;
   assign w_acc_wr = w_accept & wr;

   // Loading BANK_BUSY-1 makes the bank busy for exactly the following BANK_BUSY-1 cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 4; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (w_accept && (w_bank == 2'(i))) begin
               r_cnt[i] <= CW'(BANK_BUSY - 1);
            end else if (r_cnt[i] != '0) begin
               r_cnt[i] <= r_cnt[i] - CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc_wr) begin
         r_mem[w_word] <= data_in;
      end
   end

   // Empty pipe slots carry zero data so data_out is 0 whenever data_valid is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            r_dat[i] <= '0;
         end
      end else begin
         r_vld[0] <= w_acc_rd;
         r_dat[0] <= w_acc_rd ? r_mem[w_word] : '0;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_dat[i] <= r_dat[i-1];
         end
      end
   end

   assign data_valid = r_vld[RD_LAT-1];
   assign data_out   = r_dat[RD_LAT-1];

endmodule

// File: tb/tb_four_bank_mem_resp.sv
// Scoreboard bench for four_bank_mem_resp: a cycle-indexed bank/memory model predicts responses.
module tb_four_bank_mem_resp;

   localparam int BB = 4;
   localparam int RL = 2;

   logic        clk;
   logic        rst;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic        wr;
   logic        rd;
   logic [15:0] data_out;
   logic        data_valid;
   logic        stall;
   logic [3:0]  busy;
   logic        err;

   four_bank_mem_resp #(.AW(16), .DW(16), .BANK_BUSY(BB), .RD_LAT(RL)) dut (
      .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
      .data_out(data_out), .data_valid(data_valid), .stall(stall), .busy(busy), .err(err)
   );

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t        q[$];
   logic [15:0] mem_m [int];
   int          bank_free [4];
   int          cy;
   int          checks;
   int          errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cy = 0;
   always @(posedge clk) cy <= cy + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cy);
      end
   endtask

   function automatic logic [3:0] model_busy(input int c);
      logic [3:0] b;
      for (int i = 0; i < 4; i++) b[i] = (c < bank_free[i]);
      return b;
   endfunction

   // Response monitor: pops the scoreboard whenever the DUT presents read data.
   always @(negedge clk) begin
      exp_t e;
      if (data_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", 32'(data_valid), 32'(0));
         end else begin
            e = q.pop_front();
            chk("rd_data", 32'(data_out), 32'(e.data));
            chk("rd_due_cycle", 32'(cy), 32'(e.due));
         end
      end else begin
         chk("idle_data_out", 32'(data_out), 32'(0));
         if (q.size() != 0 && q[0].due <= cy)
            chk("missing_valid", 32'(data_valid), 32'(1));
      end
   end

   task automatic idle(input int n);
      int c;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rd = 1'b0; wr = 1'b0;
         #1;
         c = cy;
         chk("idle_busy", 32'(busy), 32'(model_busy(c)));
         chk("idle_stall", 32'(stall), 32'(0));
         chk("idle_err", 32'(err), 32'(0));
      end
   endtask

   // Presents one request and holds it until it is accepted or rejected with err.
   task automatic req(input logic r, input logic w, input logic [15:0] a,
                      input logic [15:0] d, output int stalls);
      int         c;
      int         b;
      logic       done;
      logic       e_err;
      logic       e_stall;
      logic [3:0] e_busy;
      exp_t       ex;
      stalls = 0;
      done   = 1'b0;
      for (int k = 0; k < 32 && !done; k++) begin
         @(negedge clk);
         rd = r; wr = w; addr = a; data_in = d;
         #1;
         c      = cy;
         b      = int'(a[2:1]);
         e_err  = r & w;
`ifdef MEM_ERR_CHK_EN
         e_err  = e_err | ((r | w) & (a[0] | (a >= 16'hFFFE)));
`endif
         e_busy  = model_busy(c);
         e_stall = (r | w) & ~e_err & e_busy[b];
         chk("busy", 32'(busy), 32'(e_busy));
         chk("err", 32'(err), 32'(e_err));
         chk("stall", 32'(stall), 32'(e_stall));
         @(posedge clk);
         if (e_err) begin
            done = 1'b1;
         end else if (e_stall) begin
            stalls++;
         end else begin
            if (w) mem_m[int'(a[15:1])] = d;
            if (r) begin
               ex.data = mem_m.exists(int'(a[15:1])) ? mem_m[int'(a[15:1])] : 16'h0;
               ex.due  = c + RL;
               q.push_back(ex);
            end
            bank_free[b] = c + BB;
            done = 1'b1;
         end
      end
      if (!done) chk("req_timeout", 32'(0), 32'(1));
   endtask

   initial begin
      int s;
      int op;
      logic [15:0] a;
      checks = 0; errors = 0;
      for (int i = 0; i < 4; i++) bank_free[i] = 0;
      rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_valid", 32'(data_valid), 32'(0));
      chk("rst_dout", 32'(data_out), 32'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 64; i += 2) req(1'b0, 1'b1, 16'(i), 16'($urandom), s);
      idle(5);

      // wr then read of the same bank after it frees up
      req(1'b0, 1'b1, 16'h0010, 16'hBEEF, s);
      idle(3);
      req(1'b1, 1'b0, 16'h0010, 16'h0, s);
      chk("t2_rd_stalls", 32'(s), 32'(0));
      idle(5);

      // back-to-back reads to different banks
      req(1'b1, 1'b0, 16'h0000, 16'h0, s);
      req(1'b1, 1'b0, 16'h0002, 16'h0, s);
      chk("t3_stalls", 32'(s), 32'(0));
      idle(5);

      // same-bank read stalls until the bank frees
      req(1'b1, 1'b0, 16'h0000, 16'h0, s);
      req(1'b1, 1'b0, 16'h0008, 16'h0, s);
      chk("t4_stalls", 32'(s), 32'(BB - 1));
      idle(5);

      // rd & wr together is rejected; memory must be unchanged afterwards
      req(1'b1, 1'b1, 16'h0004, 16'h1234, s);
      idle(1);
      req(1'b1, 1'b0, 16'h0004, 16'h0, s);
      idle(5);

      // unaligned write, then aligned read of the same word
      req(1'b0, 1'b1, 16'h0003, 16'hA5A5, s);
      idle(4);
      req(1'b1, 1'b0, 16'h0002, 16'h0, s);
      req(1'b0, 1'b1, 16'hFFFE, 16'h5A5A, s);
      idle(4);
      req(1'b1, 1'b0, 16'hFFFE, 16'h0, s);
      idle(5);

      // reset while a read is in flight: it must never return
      req(1'b1, 1'b0, 16'h0006, 16'h0, s);
      #2;
      rst = 1'b1;
      q.delete();
      for (int i = 0; i < 4; i++) bank_free[i] = 0;
      #1;
      chk("t1_busy", 32'(busy), 32'(0));
      chk("t1_valid", 32'(data_valid), 32'(0));
      chk("t1_dout", 32'(data_out), 32'(0));
      @(negedge clk); rd = 1'b0;
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      idle(4);

      for (int n = 0; n < 300; n++) begin
         op = int'($urandom_range(0, 10));
         a  = 16'($urandom_range(0, 63));
         if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
         if (op <= 5)       req(1'b1, 1'b0, a, 16'h0, s);
         else if (op <= 8)  req(1'b0, 1'b1, a, 16'($urandom), s);
         else if (op == 9)  idle(1);
         else               req(1'b1, 1'b1, a, 16'($urandom), s);
      end

      idle(RL + 3);
      chk("drain_empty", 32'(q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
